// File: rtl/lc3b_types.sv
// Shared LC-3b types: the data word and the stall controller state encoding.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    DMEM_WAIT  = 2'd1,
    FLUSH_PEND = 2'd2
  } lc3b_stall_state;

  localparam lc3b_word WORD_MAX = 16'hFFFF;

endpackage

// File: rtl/sat_counter.sv
// 16-bit up-counter with synchronous clear that holds at its maximum value.
module sat_counter
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     clear,
  input  logic     inc,
  output lc3b_word count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != WORD_MAX)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/bubble/flush controller for the LC-3b core.
// Optional performance counters are built when STALL_PERF_COUNTERS_EN is defined.
//
// state      | meaning
// RUN        | pipeline advancing normally, no redirect owed
// DMEM_WAIT  | data memory access outstanding, whole pipeline frozen
// FLUSH_PEND | taken branch seen but squash not yet issued
module hazard_stall_ctrl
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     mem_ex_hazard,
  input  logic     wb_ex_hazard,
  input  logic     wb_mem_hazard,
  input  logic     ex_mem_is_load,
  input  logic     ex_mem_regwrite,
  input  logic     imem_resp,
  input  logic     dmem_req,
  input  logic     dmem_resp,
  input  logic     branch_taken,
  output logic     load_pc,
  output logic     load_if_de,
  output logic     load_de_ex,
  output logic     load_ex_mem,
  output logic     load_mem_wb,
  output logic     bubble_de_ex,
  output logic     bubble_ex_mem,
  output logic     flush_if_de,
  output logic     flush_de_ex,
  output logic     flush_ex_mem,
  output lc3b_word stall_cycles,
  output lc3b_word flush_count
);

  lc3b_stall_state state, state_next;
  logic flush_owed, owed_next;
  logic lu_prev, lu_issue;
  logic flush_issue;
  logic dmem_wait, load_use;

  // WB-stage hazards are resolved by forwarding and never stall.
  logic unused_wb;
  assign unused_wb = &{1'b0, wb_ex_hazard, wb_mem_hazard};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      flush_owed <= 1'b0;
      lu_prev    <= 1'b0;
    end else begin
      state      <= state_next;
      flush_owed <= owed_next;
      lu_prev    <= lu_issue;
    end
  end

  assign dmem_wait = (dmem_req || (state == DMEM_WAIT)) && !dmem_resp;
  // The cycle after a load-use bubble the operand comes from WB forwarding.
  assign load_use  = mem_ex_hazard && ex_mem_is_load && ex_mem_regwrite && !lu_prev;

  always_comb begin
    load_pc       = 1'b1;
    load_if_de    = 1'b1;
    load_de_ex    = 1'b1;
    load_ex_mem   = 1'b1;
    load_mem_wb   = 1'b1;
    bubble_de_ex  = 1'b0;
    bubble_ex_mem = 1'b0;
    flush_issue   = 1'b0;
    lu_issue      = 1'b0;
    owed_next     = flush_owed;
    state_next    = RUN;
    if (!reset) begin
      if (dmem_wait) begin
        load_pc     = 1'b0;
        load_if_de  = 1'b0;
        load_de_ex  = 1'b0;
        load_ex_mem = 1'b0;
        load_mem_wb = 1'b0;
        owed_next   = flush_owed || branch_taken;
      end else if (load_use) begin
        load_pc       = 1'b0;
        load_if_de    = 1'b0;
        load_de_ex    = 1'b0;
        bubble_ex_mem = 1'b1;
        lu_issue      = 1'b1;
        owed_next     = flush_owed || branch_taken;
      end else if (!imem_resp) begin
        load_pc      = 1'b0;
        load_if_de   = 1'b0;
        bubble_de_ex = 1'b1;
        owed_next    = flush_owed || branch_taken;
      end else if (branch_taken || flush_owed) begin
        flush_issue = 1'b1;
        owed_next   = 1'b0;
      end
      if (dmem_wait)      state_next = DMEM_WAIT;
      else if (owed_next) state_next = FLUSH_PEND;
      else                state_next = RUN;
    end
  end

  assign flush_if_de  = flush_issue;
  assign flush_de_ex  = flush_issue;
  assign flush_ex_mem = flush_issue;

`ifdef STALL_PERF_COUNTERS_EN
  sat_counter u_stall_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (!load_pc),
    .count (stall_cycles)
  );

  sat_counter u_flush_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (flush_issue),
    .count (flush_count)
  );
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: per-cycle priority model plus directed scenarios.
module tb_hazard_stall_ctrl;

`ifdef STALL_PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, mem_ex_hazard, wb_ex_hazard, wb_mem_hazard;
  logic ex_mem_is_load, ex_mem_regwrite, imem_resp, dmem_req, dmem_resp, branch_taken;
  logic load_pc, load_if_de, load_de_ex, load_ex_mem, load_mem_wb;
  logic bubble_de_ex, bubble_ex_mem, flush_if_de, flush_de_ex, flush_ex_mem;
  logic [15:0] stall_cycles, flush_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl dut (
    .clk(clk), .reset(reset), .mem_ex_hazard(mem_ex_hazard),
    .wb_ex_hazard(wb_ex_hazard), .wb_mem_hazard(wb_mem_hazard),
    .ex_mem_is_load(ex_mem_is_load), .ex_mem_regwrite(ex_mem_regwrite),
    .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .branch_taken(branch_taken), .load_pc(load_pc), .load_if_de(load_if_de),
    .load_de_ex(load_de_ex), .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .bubble_de_ex(bubble_de_ex), .bubble_ex_mem(bubble_ex_mem),
    .flush_if_de(flush_if_de), .flush_de_ex(flush_de_ex), .flush_ex_mem(flush_ex_mem),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; returns at posedge+4 so literal checks see settled outputs.
  task automatic apply(input logic rst, input logic hz, input logic ld, input logic rw,
                       input logic im, input logic dq, input logic dr, input logic br);
    @(posedge clk);
    #1;
    reset = rst; mem_ex_hazard = hz; ex_mem_is_load = ld; ex_mem_regwrite = rw;
    imem_resp = im; dmem_req = dq; dmem_resp = dr; branch_taken = br;
    wb_ex_hazard = 1'($urandom); wb_mem_hazard = 1'($urandom);
    #3;
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 1, 0, 0, 0);
  endtask

  // Model: classify the cycle by priority, outputs follow from the class alone.
  // Vector order: load_pc,if_de,de_ex,ex_mem,mem_wb, bubble_de_ex,ex_mem, flush x3.
  localparam int C_RST = 0, C_DMEM = 1, C_LU = 2, C_IMEM = 3, C_FLUSH = 4, C_NONE = 5;
  logic m_owed = 1'b0;
  logic m_lu_prev = 1'b0;
  int   m_stall = 0;
  int   m_flush = 0;

  always @(negedge clk) begin
    int cat;
    logic [9:0] exp_v, act_v;
    if (reset) cat = C_RST;
    else if (dmem_req && !dmem_resp) cat = C_DMEM;
    else if (mem_ex_hazard && ex_mem_is_load && ex_mem_regwrite && !m_lu_prev) cat = C_LU;
    else if (!imem_resp) cat = C_IMEM;
    else if (branch_taken || m_owed) cat = C_FLUSH;
    else cat = C_NONE;
    case (cat)
      C_DMEM:  exp_v = 10'b00000_00_000;
      C_LU:    exp_v = 10'b00011_01_000;
      C_IMEM:  exp_v = 10'b00111_10_000;
      C_FLUSH: exp_v = 10'b11111_00_111;
      default: exp_v = 10'b11111_00_000;
    endcase
    act_v = {load_pc, load_if_de, load_de_ex, load_ex_mem, load_mem_wb,
             bubble_de_ex, bubble_ex_mem, flush_if_de, flush_de_ex, flush_ex_mem};
    chk("model_outputs", 16'(act_v), 16'(exp_v));
    chk("model_stall_cycles", stall_cycles, 16'(m_stall));
    chk("model_flush_count", flush_count, 16'(m_flush));
    if (cat == C_RST) begin
      m_owed = 1'b0; m_lu_prev = 1'b0; m_stall = 0; m_flush = 0;
    end else begin
      m_lu_prev = (cat == C_LU);
      m_owed = (cat == C_FLUSH) ? 1'b0 : (m_owed || branch_taken);
      if (PERF && !exp_v[9] && m_stall < 65535) m_stall++;
      if (PERF && cat == C_FLUSH && m_flush < 65535) m_flush++;
    end
  end

  initial begin
    reset = 1; mem_ex_hazard = 0; wb_ex_hazard = 0; wb_mem_hazard = 0;
    ex_mem_is_load = 0; ex_mem_regwrite = 0; imem_resp = 1;
    dmem_req = 0; dmem_resp = 0; branch_taken = 0;

    // Reset holds outputs at pass-through even with a dmem wait and branch present.
    apply(1, 0, 0, 0, 0, 1, 0, 1);
    chk("reset_load_pc", 16'(load_pc), 16'd1);
    chk("reset_load_mem_wb", 16'(load_mem_wb), 16'd1);
    chk("reset_flush", 16'(flush_if_de), 16'd0);
    idle();
    chk("idle_enables", 16'({load_pc, load_if_de, load_de_ex, load_ex_mem, load_mem_wb}), 16'h1F);
    chk("idle_counters", stall_cycles | flush_count, 16'd0);

    // Load-use: one bubble cycle even if the hazard stays visible.
    apply(0, 1, 1, 1, 1, 0, 0, 0);
    chk("lu_load_pc", 16'(load_pc), 16'd0);
    chk("lu_bubble_ex_mem", 16'(bubble_ex_mem), 16'd1);
    chk("lu_load_ex_mem", 16'(load_ex_mem), 16'd1);
    apply(0, 1, 1, 1, 1, 0, 0, 0);
    chk("lu_second_cycle_load_pc", 16'(load_pc), 16'd1);
    chk("lu_second_cycle_bubble", 16'(bubble_ex_mem), 16'd0);
    idle();

    // Dmem wait of 3 cycles.
    apply(1, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 0, 1, 1, 0, 0);
      chk("dmem_wait_enables", 16'({load_pc, load_if_de, load_de_ex, load_ex_mem, load_mem_wb}), 16'h00);
    end
    apply(0, 0, 0, 0, 1, 1, 1, 0);
    chk("dmem_resp_enables", 16'({load_pc, load_if_de, load_de_ex, load_ex_mem, load_mem_wb}), 16'h1F);
    idle();
    chk("dmem_stall_cycles", stall_cycles, PERF ? 16'd3 : 16'd0);

    // Branch during imem miss.
    apply(1, 0, 0, 0, 1, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 1);
    chk("br_imiss_flush0", 16'(flush_de_ex), 16'd0);
    chk("br_imiss_bubble_de_ex", 16'(bubble_de_ex), 16'd1);
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    chk("br_imiss_flush1", 16'(flush_de_ex), 16'd0);
    apply(0, 0, 0, 0, 1, 0, 0, 0);
    chk("br_pending_flush", 16'({flush_if_de, flush_de_ex, flush_ex_mem}), 16'd7);
    chk("br_pending_load_pc", 16'(load_pc), 16'd1);
    idle();
    chk("br_after_flush", 16'(flush_ex_mem), 16'd0);
    chk("br_flush_count", flush_count, PERF ? 16'd1 : 16'd0);
    chk("br_stall_cycles", stall_cycles, PERF ? 16'd2 : 16'd0);

    // Load-use + imem miss + branch together; then double branch while pending.
    apply(0, 1, 1, 1, 0, 0, 0, 1);
    chk("combo_lu_wins", 16'({load_pc, bubble_ex_mem, bubble_de_ex, flush_if_de}), 16'b0100);
    idle();
    chk("combo_flush_next", 16'(flush_if_de), 16'd1);
    apply(0, 0, 0, 0, 0, 0, 0, 1);
    apply(0, 0, 0, 0, 0, 0, 0, 1);
    apply(0, 0, 0, 0, 1, 0, 0, 1);
    chk("double_br_flush", 16'(flush_if_de), 16'd1);
    idle();
    chk("double_br_no_second", 16'(flush_if_de), 16'd0);

    // Branch remembered through a dmem wait.
    apply(0, 0, 0, 0, 1, 1, 0, 1);
    chk("br_in_dmem_no_flush", 16'(flush_if_de), 16'd0);
    apply(0, 0, 0, 0, 1, 1, 0, 0);
    apply(0, 0, 0, 0, 1, 1, 1, 0);
    chk("dmem_exit_flush", 16'(flush_if_de), 16'd1);
    idle();

    // Reset in the middle of a dmem wait with a branch owed.
    apply(0, 0, 0, 0, 1, 1, 0, 1);
    apply(0, 0, 0, 0, 1, 1, 0, 0);
    apply(1, 0, 0, 0, 1, 1, 0, 0);
    chk("rst_mid_wait_enables", 16'({load_pc, load_if_de, load_de_ex, load_ex_mem, load_mem_wb}), 16'h1F);
    idle();
    chk("after_rst_enables", 16'({load_pc, load_if_de, load_de_ex, load_ex_mem, load_mem_wb}), 16'h1F);
    chk("after_rst_no_flush", 16'(flush_if_de), 16'd0);
    chk("after_rst_counters", stall_cycles | flush_count, 16'd0);

    // Saturation.
    apply(1, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 70000; i++) apply(0, 0, 0, 0, 1, 1, 0, 0);
    apply(0, 0, 0, 0, 1, 1, 1, 0);
    idle();
    chk("stall_saturated", stall_cycles, PERF ? 16'hFFFF : 16'd0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 SHALL have ports, clock and reset first: clk in 1, single clock, all state updates on rising edge.
REQ-002 SHALL have reset in 1: synchronous, active-high.
REQ-003 SHALL have mem_ex_hazard in 1: EX/MEM destination matches a DE/EX source (from hazard_detection).
REQ-004 SHALL have wb_ex_hazard in 1 and wb_mem_hazard in 1: informational, no stall effect.
REQ-005 SHALL have ex_mem_is_load in 1 and ex_mem_regwrite in 1: qualifiers for the MEM-stage instruction.
REQ-006 SHALL have imem_resp in 1, dmem_req in 1, dmem_resp in 1: memory handshakes.
REQ-007 SHALL have branch_taken in 1: MEM-stage redirect.
REQ-008 SHALL have load_pc, load_if_de, load_de_ex, load_ex_mem, load_mem_wb out 1 each: register enables.
REQ-009 SHALL have bubble_de_ex, bubble_ex_mem out 1 each: load a NOP in place of the incoming instruction.
REQ-010 SHALL have flush_if_de, flush_de_ex, flush_ex_mem out 1 each: squash on redirect.
REQ-011 SHALL have stall_cycles out 16 and flush_count out 16: performance counters (lc3b_word).

Function
REQ-012 SHALL implement states RUN, DMEM_WAIT, FLUSH_PEND; outputs are Mealy (state + inputs).
REQ-013 Priority SHALL be: dmem wait > load-use > imem wait > branch flush.
REQ-014 Dmem wait: dmem_req=1 and dmem_resp=0 SHALL drop all five enables to 0 and go to DMEM_WAIT, or stay there.
REQ-015 DMEM_WAIT SHALL exit on dmem_resp=1. In that same cycle it SHALL act as RUN. The next state SHALL be FLUSH_PEND if a flush is still owed, else RUN.
REQ-016 Load-use: mem_ex_hazard & ex_mem_is_load & ex_mem_regwrite SHALL hold load_pc, load_if_de and load_de_ex at 0, assert bubble_ex_mem, and keep load_ex_mem=load_mem_wb=1.
REQ-017 Load-use SHALL last exactly one cycle. On the following cycle, wb_ex forwarding covers the operand.
REQ-018 Imem wait: imem_resp=0 SHALL drop load_pc and load_if_de and assert bubble_de_ex. Downstream stages SHALL advance.
REQ-019 branch_taken with imem_resp=1 and no higher-priority stall SHALL assert flush_if_de, flush_de_ex and flush_ex_mem for one cycle. load_pc SHALL stay 1.
REQ-020 branch_taken while imem_resp=0 or in dmem wait SHALL latch a pending flush and enter FLUSH_PEND (or remember it through DMEM_WAIT).
REQ-021 FLUSH_PEND SHALL issue the three flushes on the first cycle with imem_resp=1 and no dmem wait, then return to RUN.
REQ-022 A second branch_taken while a flush is pending SHALL NOT queue a second flush.
REQ-023 With no stall, flush or hazard, all enables SHALL be 1 and all bubbles and flushes SHALL be 0.

Reset
REQ-024 Reset SHALL force the state to RUN, clear the pending flush, and zero both counters.
REQ-025 Reset SHALL dominate all inputs, including mid-DMEM_WAIT and mid-FLUSH_PEND.
REQ-026 While reset=1, outputs SHALL be: enables 1, bubbles 0, flushes 0.

Configuration
REQ-027 Macro STALL_PERF_COUNTERS_EN defined: stall_cycles SHALL increment on every cycle where load_pc=0.
REQ-028 With the macro defined, flush_count SHALL increment per issued flush. Both counters SHALL saturate at 0xFFFF.
REQ-029 Macro undefined: both counter ports SHALL remain present, tied to 0, with no counter flops.

Structure
REQ-030 The state enum lc3b_stall_state SHALL live in lc3b_types, alongside lc3b_word.
REQ-031 A sub-module sat_counter SHALL be used for each counter: 16-bit, with inc, clear and saturate.

Verification
REQ-032 Load x6 from R2 with R2 consumed next: one cycle with load_pc=0 and bubble_ex_mem=1, then all enables 1.
REQ-033 dmem_req=1 with dmem_resp delayed 3 cycles: all enables 0 for 3 cycles, then 1; stall_cycles=3 with macro, 0 without.
REQ-034 branch_taken with imem_resp=0 for 2 cycles: no flush until imem_resp=1; three flushes for one cycle; flush_count=1.
REQ-035 load-use, imem miss and branch_taken in the same cycle: load-use wins, branch latched, flush on the next clean cycle.
REQ-036 reset=1 asserted during DMEM_WAIT: the next cycle is RUN with enables 1 and counters 0.
REQ-037 Force 70000 stall cycles: stall_cycles holds at 0xFFFF.
